rf_exec_ctrl: RTL and testbench
===============================

RF_EXEC_CTRL -- requirements
Module: rf_exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and datapath width.
REQ-002 SHALL have parameter ADDR_W, default 2, meaning register address width (4 entries).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning an instruction is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an instruction this cycle.
REQ-007 SHALL have port in_instr, input, 16, meaning the instruction: op[15:12], rd[11:10], rs1[9:8], rs2[7:6], imm[5:0].
REQ-008 SHALL have port res_valid, output, 1, meaning a result is presented.
REQ-009 SHALL have port res_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port res_data, output, DATA_W, meaning the computed result.
REQ-011 SHALL have port res_err, output, 1, meaning an illegal opcode.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-013 SHALL have port rf_addr, output, ADDR_W, meaning the register-file address.
REQ-014 SHALL have port rf_wen, output, 1, meaning the register-file write enable (0 = read).
REQ-015 SHALL have port rf_ren, output, 1, meaning the register-file read strobe.
REQ-016 SHALL have port rf_data_in, output, DATA_W, meaning the register-file write data.
REQ-017 SHALL have port rf_data_out, input, DATA_W, meaning the register-file registered read data; it is valid one cycle after the address is driven with rf_wen=0, and address 0 reads 0.

Function
REQ-018 SHALL implement states IDLE, RDA, RDB, EXE, WB, RSP.
REQ-019 SHALL in IDLE: in_ready=1; on in_valid, latch in_instr and go to RDA; otherwise stay in IDLE.
REQ-020 SHALL in RDA: drive rf_addr=rs1, rf_wen=0, rf_ren=1, then go to RDB.
REQ-021 SHALL in RDB: drive rf_addr=rs2, rf_wen=0, rf_ren=1, capture opA=rf_data_out, then go to EXE.
REQ-022 SHALL in EXE: capture opB=rf_data_out, drive rf_wen=0 and rf_ren=0, register the result, then go to WB.
REQ-023 SHALL decode ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 ADDI A+sext(imm); 6 LI zext(imm); 7 SLL A<<B[4:0]; 8 SRL A>>B[4:0] logical.
REQ-024 SHALL perform all arithmetic modulo 2^DATA_W, with no carry or overflow flag.
REQ-025 SHALL treat ops 9-15 as illegal: result 0 and err=1.
REQ-026 SHALL in WB: for legal ops with rd!=0, drive rf_wen=1 for exactly one cycle with rf_addr=rd and rf_data_in=result.
REQ-027 SHALL in WB: for rd=0 or an illegal op, keep rf_wen=0; then go to RSP.
REQ-028 SHALL in RSP: res_valid=1 with res_data and res_err stable; on res_ready, go to IDLE; otherwise hold.
REQ-029 SHALL fix latency from the accept edge to res_valid=1 at 4 cycles, with throughput of at most 1 instruction per 5 cycles.
REQ-030 SHALL keep in_ready=0 in every state other than IDLE, ignoring in_valid there; an accepted instruction is never lost.
REQ-031 SHALL keep res_valid=0 and rf_wen=0 in every state other than RSP and WB respectively.
REQ-032 SHALL keep in_ready=0 and res_valid=0 in the RSP cycle where res_ready=1; a new instruction is accepted at the earliest on the following IDLE cycle.
REQ-033 SHALL drive rf_data_in=0 whenever rf_wen=0.

Reset
REQ-034 SHALL, while rst_n=0, force state=IDLE, in_ready=0, res_valid=0, res_err=0, res_data=0, busy=0, rf_wen=0, rf_ren=0, rf_addr=0, rf_data_in=0, and clear all latched instruction and operand registers.
REQ-035 SHALL abort any operation in progress on reset assertion, with no register-file write issued after rst_n falls.
REQ-036 SHALL assert in_ready=1 in the first cycle after rst_n rises.

Verification
REQ-037 SHALL cover: RF r1=5, r2=7; ADD rd=3 rs1=1 rs2=2 -> WB writes r3=12; res_data=12 four cycles after accept.
REQ-038 SHALL cover: r1=3; ADDI rd=2 rs1=1 imm=6'b111110 -> r2=1, res_data=1, res_err=0.
REQ-039 SHALL cover: LI rd=0 imm=9 -> rf_wen stays 0 throughout; res_data=9.
REQ-040 SHALL cover: op=12 -> res_err=1, res_data=0, no write.
REQ-041 SHALL cover: res_ready held 0 for 6 cycles in RSP with in_valid=1 -> res_valid and res_data stable, in_ready=0, second instruction accepted only after the handshake.
REQ-042 SHALL cover: rst_n pulled low during EXE of SUB rd=1 -> outputs zeroed immediately, r1 unchanged, in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/rf_exec_ctrl.sv
// Sequencing controller: reads two operands from an external registered-read
// register file, executes one ALU op, writes back, then hands the result out.
module rf_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_wen,
  output logic              rf_ren,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXE, S_WB, S_RSP} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [5:0] imm;
  } instr_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;

  state_t              st, nxt;
  instr_t              instr_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   res_q;
  logic                err_q;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_err;
  logic [DATA_W-1:0]   opb;
  logic                wb_en;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:  if (in_valid) nxt = S_RDA;
      S_RDA:   nxt = S_RDB;
      S_RDB:   nxt = S_EXE;
      S_EXE:   nxt = S_WB;
      S_WB:    nxt = S_RSP;
      S_RSP:   if (res_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  assign wb_en = (st == S_WB) && !err_q && (instr_q.rd != 2'd0);

  // ---------------- outputs ----------------
  // in_ready is gated by rst_n so it is low throughout reset even though
  // the state register already sits in IDLE.
  always_comb begin
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = (st != S_IDLE);
    rf_addr    = '0;
    rf_wen     = 1'b0;
    rf_ren     = 1'b0;
    rf_data_in = '0;
    unique case (st)
      S_IDLE: in_ready = rst_n;
      S_RDA: begin
        rf_addr = ADDR_W'(instr_q.rs1);
        rf_ren  = 1'b1;
      end
      S_RDB: begin
        rf_addr = ADDR_W'(instr_q.rs2);
        rf_ren  = 1'b1;
      end
      S_WB: begin
        if (wb_en) begin
          rf_addr    = ADDR_W'(instr_q.rd);
          rf_wen     = 1'b1;
          rf_data_in = res_q;
        end
      end
      S_RSP:   res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data = res_q;
  assign res_err  = err_q;

  // ---------------- ALU ----------------
  // Operand B is consumed straight off the registered read port in EXE;
  // the result register is the only place it needs to land.
  assign opb = rf_data_out;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (instr_q.op)
      OP_ADD:  alu_res = opa_q + opb;
      OP_SUB:  alu_res = opa_q - opb;
      OP_AND:  alu_res = opa_q & opb;
      OP_OR:   alu_res = opa_q | opb;
      OP_XOR:  alu_res = opa_q ^ opb;
      OP_ADDI: alu_res = opa_q + {{(DATA_W-6){instr_q.imm[5]}}, instr_q.imm};
      OP_LI:   alu_res = {{(DATA_W-6){1'b0}}, instr_q.imm};
      OP_SLL:  alu_res = opa_q << opb[4:0];
      OP_SRL:  alu_res = opa_q >> opb[4:0];
      default: alu_err = 1'b1;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      opa_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (st == S_IDLE && in_valid) instr_q <= instr_t'(in_instr);
      if (st == S_RDB)              opa_q   <= rf_data_out;
      if (st == S_EXE) begin
        res_q <= alu_res;
        err_q <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl with a behavioural registered-read RF.
module tb_rf_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;
  logic [1:0]  rf_addr;
  logic        rf_wen;
  logic        rf_ren;
  logic [31:0] rf_data_in;
  logic [31:0] rf_data_out;

  rf_exec_ctrl #(.DATA_W(32), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .rf_addr(rf_addr), .rf_wen(rf_wen), .rf_ren(rf_ren),
    .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  always #5 clk = ~clk;

  // register file model: registered read, r0 reads zero, bench-side load port
  logic [31:0] rf [4];
  logic        ld_en = 1'b0;
  logic [1:0]  ld_a  = '0;
  logic [31:0] ld_d  = '0;
  int          wr_cnt = 0;
  int          bad_wdata = 0;

  always @(posedge clk) begin
    if (ld_en) rf[ld_a] <= ld_d;
    else if (rf_wen) begin
      rf[rf_addr] <= rf_data_in;
      wr_cnt      <= wr_cnt + 1;
    end
    rf_data_out <= (rf_addr == 2'd0) ? 32'd0 : rf[rf_addr];
  end

  always @(negedge clk) if (!rf_wen && rf_data_in != 32'd0) bad_wdata++;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic [5:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic load(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Offers ins from IDLE and returns at the negedge where res_valid is seen.
  task automatic issue(input string tag, input logic [15:0] ins, output int lat,
                       output int wrs);
    int w0;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    w0 = wr_cnt;
    in_instr = ins; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    wrs = wr_cnt - w0;
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_post_rdy"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_post_vld"}, {31'd0, res_valid}, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [5:0]  imm;
    logic [31:0] a, b, exp;
    logic        err;
    logic        wr;
  } vec_t;

  vec_t vt [12];

  initial begin
    int lat, wrs;
    logic [31:0] r1_before;
    string tg;

    vt[0]  = '{4'd0,  2'd3, 2'd1, 2'd2, 6'd0,      32'd5,        32'd7,        32'd12,       1'b0, 1'b1};
    vt[1]  = '{4'd1,  2'd3, 2'd1, 2'd2, 6'd0,      32'd5,        32'd7,        32'hFFFF_FFFE, 1'b0, 1'b1};
    vt[2]  = '{4'd2,  2'd3, 2'd1, 2'd2, 6'd0,      32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b1};
    vt[3]  = '{4'd3,  2'd3, 2'd1, 2'd2, 6'd0,      32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b1};
    vt[4]  = '{4'd4,  2'd3, 2'd1, 2'd2, 6'd0,      32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b1};
    vt[5]  = '{4'd5,  2'd2, 2'd1, 2'd0, 6'b111110, 32'd3,        32'd0,        32'd1,        1'b0, 1'b1};
    vt[6]  = '{4'd6,  2'd0, 2'd1, 2'd2, 6'd9,      32'd1,        32'd2,        32'd9,        1'b0, 1'b0};
    vt[7]  = '{4'd7,  2'd3, 2'd1, 2'd2, 6'd0,      32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1'b1};
    vt[8]  = '{4'd8,  2'd3, 2'd1, 2'd2, 6'd0,      32'h8000_0000, 32'd31,       32'd1,        1'b0, 1'b1};
    vt[9]  = '{4'd12, 2'd3, 2'd1, 2'd2, 6'd5,      32'd5,        32'd7,        32'd0,        1'b1, 1'b0};
    vt[10] = '{4'd15, 2'd1, 2'd1, 2'd2, 6'd5,      32'd5,        32'd7,        32'd0,        1'b1, 1'b0};
    vt[11] = '{4'd0,  2'd3, 2'd0, 2'd2, 6'd0,      32'd99,       32'd7,        32'd7,        1'b0, 1'b1};

    for (int i = 0; i < 4; i++) rf[i] = 32'd0;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; res_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   {31'd0, in_ready},  32'd0);
    chk("rst_busy",       {31'd0, busy},      32'd0);
    chk("rst_res_valid",  {31'd0, res_valid}, 32'd0);
    chk("rst_res_err",    {31'd0, res_err},   32'd0);
    chk("rst_res_data",   res_data,           32'd0);
    chk("rst_rf_wen",     {31'd0, rf_wen},    32'd0);
    chk("rst_rf_ren",     {31'd0, rf_ren},    32'd0);
    chk("rst_rf_addr",    {30'd0, rf_addr},   32'd0);
    chk("rst_rf_data_in", rf_data_in,         32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // table-driven single instructions
    for (int i = 0; i < 12; i++) begin
      tg = $sformatf("v%0d", i);
      if (vt[i].rs1 != 2'd0) load(vt[i].rs1, vt[i].a);
      if (vt[i].rs2 != 2'd0 && vt[i].rs2 != vt[i].rs1) load(vt[i].rs2, vt[i].b);
      issue(tg, enc(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm), lat, wrs);
      chk({tg, "_latency"}, lat, 32'd4);
      chk({tg, "_data"}, res_data, vt[i].exp);
      chk({tg, "_err"}, {31'd0, res_err}, {31'd0, vt[i].err});
      chk({tg, "_writes"}, wrs, vt[i].wr ? 32'd1 : 32'd0);
      if (vt[i].wr) chk({tg, "_rf_rd"}, rf[vt[i].rd], vt[i].exp);
      handshake(tg);
    end

    // backpressure in RSP with a second instruction waiting
    load(2'd1, 32'd5);
    load(2'd2, 32'd7);
    issue("bp", enc(4'd0, 2'd3, 2'd1, 2'd2, 6'd0), lat, wrs);
    chk("bp_latency", lat, 32'd4);
    in_instr = enc(4'd6, 2'd3, 2'd0, 2'd0, 6'd33);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_vld", k), {31'd0, res_valid}, 32'd1);
      chk($sformatf("bp_hold%0d_data", k), res_data, 32'd12);
      chk($sformatf("bp_hold%0d_rdy", k), {31'd0, in_ready}, 32'd0);
    end
    res_ready = 1'b1;
    chk("bp_hs_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_idle_rdy",  {31'd0, in_ready}, 32'd1);
    chk("bp_idle_busy", {31'd0, busy},     32'd0);
    chk("bp_idle_vld",  {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_2nd_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!res_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_2nd_latency", lat, 32'd4);
    chk("bp_2nd_data", res_data, 32'd33);
    chk("bp_2nd_rf", rf[3], 32'd33);
    handshake("bp2");

    // reset asserted while SUB sits in EXE
    load(2'd1, 32'd50);
    load(2'd2, 32'd8);
    r1_before = 32'd50;
    @(negedge clk);
    wrs = wr_cnt;
    in_instr = enc(4'd1, 2'd1, 2'd1, 2'd2, 6'd0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_exe_busy", {31'd0, busy},   32'd1);
    chk("ar_exe_ren",  {31'd0, rf_ren}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy",    {31'd0, busy},      32'd0);
    chk("ar_rdy",     {31'd0, in_ready},  32'd0);
    chk("ar_vld",     {31'd0, res_valid}, 32'd0);
    chk("ar_wen",     {31'd0, rf_wen},    32'd0);
    chk("ar_data",    res_data,           32'd0);
    chk("ar_wdata",   rf_data_in,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rel_rdy", {31'd0, in_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("ar_r1_kept", rf[1], r1_before);
    chk("ar_no_write", wr_cnt - wrs, 32'd0);
    chk("ar_idle_vld", {31'd0, res_valid}, 32'd0);

    chk("wdata_zero_when_idle", bad_wdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
